// File: rtl/sync_timing_monitor.sv
// Receive-side video timing monitor: measures h/v timing from h_sync, v_sync and
// active, publishes results once per frame and asserts locked once they stay stable.
module sync_timing_monitor #(
   parameter int H_W         = 12,
   parameter int V_W         = 10,
   parameter int LOCK_FRAMES = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           h_sync,
   input  logic           v_sync,
   input  logic           active,
   output logic [H_W-1:0] h_total,
   output logic [H_W-1:0] h_active,
   output logic [H_W-1:0] h_sync_width,
   output logic [V_W-1:0] v_total,
   output logic [V_W-1:0] v_active,
   output logic [V_W-1:0] v_sync_width,
   output logic           frame_valid,
   output logic           locked,
   output logic           error
);

   localparam logic [H_W-1:0] H_ONE  = H_W'(1);
   localparam logic [H_W-1:0] H_MAX  = {H_W{1'b1}};
   localparam logic [H_W-1:0] H_PRE  = H_MAX - H_ONE;
   localparam logic [V_W-1:0] V_ONE  = V_W'(1);
   localparam logic [V_W-1:0] V_MAX  = {V_W{1'b1}};
   localparam logic [V_W-1:0] V_PRE  = V_MAX - V_ONE;
   localparam logic [3:0]     LOCK_N = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   state_t         state;
   logic [3:0]     match_cnt;

   logic           h_sync_q, h_sync_qq, v_sync_q, v_sync_qq, active_q;
   logic [H_W-1:0] pc, ac, first_len, first_ac, hsw;
   logic [V_W-1:0] lc, vsc, vac;
   logic           line_seen, h_ok;

   logic           line_start, frame_start, h_fall, line_end;
   logic           pc_ovf, lc_ovf, ovf;
   logic           len_bad, ac_bad, line_bad, h_ok_end;
   logic [H_W-1:0] first_len_end, first_ac_end;
   logic [V_W-1:0] vac_end;
   logic           same, match_ok;
   logic [3:0]     mc_next;

   assign line_start  = h_sync_q & ~h_sync_qq;
   assign frame_start = v_sync_q & ~v_sync_qq;
   assign h_fall      = ~h_sync_q & h_sync_qq;
   // The very first line start after reset/overflow has no measured line behind it.
   assign line_end    = line_start & line_seen;

   assign pc_ovf = ~line_start && (pc == H_PRE);
   assign lc_ovf = line_start && ~frame_start && (lc == V_PRE);
   assign ovf    = pc_ovf | lc_ovf;

   assign len_bad  = line_end && (first_len != '0) && (pc != first_len);
   assign ac_bad   = line_end && (ac != '0) && (first_ac != '0) && (ac != first_ac);
   assign line_bad = len_bad | ac_bad;
   assign h_ok_end = h_ok & ~line_bad;

   // "_end" values fold in a line that ends on the frame-start cycle.
   assign first_len_end = (line_end && first_len == '0) ? pc : first_len;
   assign first_ac_end  = (line_end && first_ac == '0) ? ac : first_ac;
   assign vac_end       = (line_end && ac != '0) ? vac + V_ONE : vac;

   assign same = (h_total == first_len_end) && (h_active == first_ac_end) &&
                 (h_sync_width == hsw) && (v_total == lc) &&
                 (v_active == vac_end) && (v_sync_width == vsc);
   assign match_ok = h_ok_end & same;
   assign mc_next  = match_ok ? match_cnt + 4'd1 : 4'd0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_sync_q  <= 1'b0;
         h_sync_qq <= 1'b0;
         v_sync_q  <= 1'b0;
         v_sync_qq <= 1'b0;
         active_q  <= 1'b0;
         pc        <= '0;
         ac        <= '0;
         first_len <= '0;
         first_ac  <= '0;
         hsw       <= '0;
         lc        <= '0;
         vsc       <= '0;
         vac       <= '0;
         line_seen <= 1'b0;
         h_ok      <= 1'b0;
      end else begin
         h_sync_q  <= h_sync;
         h_sync_qq <= h_sync_q;
         v_sync_q  <= v_sync;
         v_sync_qq <= v_sync_q;
         active_q  <= active;

         if (line_start)
            pc <= H_ONE;
         else if (pc != H_MAX)
            pc <= pc + H_ONE;

         if (line_start)
            ac <= active_q ? H_ONE : '0;
         else if (active_q && ac != H_MAX)
            ac <= ac + H_ONE;

         if (h_fall)
            hsw <= pc;

         if (ovf)
            line_seen <= 1'b0;
         else if (line_start)
            line_seen <= 1'b1;

         if (frame_start) begin
            first_len <= '0;
            first_ac  <= '0;
            vac       <= '0;
            h_ok      <= 1'b1;
            lc        <= V_ONE;
            vsc       <= line_start ? V_ONE : '0;
         end else begin
            if (line_end) begin
               first_len <= first_len_end;
               first_ac  <= first_ac_end;
               vac       <= vac_end;
               h_ok      <= h_ok_end;
            end
            if (line_start && lc != V_MAX)
               lc <= lc + V_ONE;
            if (line_start && v_sync_q && vsc != V_MAX)
               vsc <= vsc + V_ONE;
         end
         if (ovf)
            h_ok <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= SEARCH;
         match_cnt    <= 4'd0;
         h_total      <= '0;
         h_active     <= '0;
         h_sync_width <= '0;
         v_total      <= '0;
         v_active     <= '0;
         v_sync_width <= '0;
         frame_valid  <= 1'b0;
         locked       <= 1'b0;
         error        <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         error       <= ovf | (line_bad & h_ok);
         if (ovf) begin
            state        <= SEARCH;
            match_cnt    <= 4'd0;
            h_total      <= '0;
            h_active     <= '0;
            h_sync_width <= '0;
            v_total      <= '0;
            v_active     <= '0;
            v_sync_width <= '0;
            locked       <= 1'b0;
         end else if (frame_start) begin
            if (state == SEARCH) begin
               state     <= MEASURE;
               match_cnt <= 4'd0;
            end else begin
               h_total      <= first_len_end;
               h_active     <= first_ac_end;
               h_sync_width <= hsw;
               v_total      <= lc;
               v_active     <= vac_end;
               v_sync_width <= vsc;
               frame_valid  <= 1'b1;
               if (match_ok && mc_next >= LOCK_N) begin
                  state     <= LOCKED;
                  match_cnt <= LOCK_N;
                  locked    <= 1'b1;
               end else begin
                  state     <= MEASURE;
                  match_cnt <= mc_next;
                  locked    <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sync_timing_monitor.sv
// Directed bench for sync_timing_monitor: a small in-bench video generator drives
// frames; a negedge monitor records frame_valid/error events for the test tasks.
module tb_sync_timing_monitor;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        h_sync = 1'b0;
   logic        v_sync = 1'b0;
   logic        active = 1'b0;
   logic [11:0] h_total, h_active, h_sync_width;
   logic [9:0]  v_total, v_active, v_sync_width;
   logic        frame_valid, locked, error;

   sync_timing_monitor dut (
      .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .active(active),
      .h_total(h_total), .h_active(h_active), .h_sync_width(h_sync_width),
      .v_total(v_total), .v_active(v_active), .v_sync_width(v_sync_width),
      .frame_valid(frame_valid), .locked(locked), .error(error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int fv_cnt = 0;
   int err_cnt = 0;
   logic        lock_hist [0:255];
   logic [11:0] s_ht, s_ha, s_hsw;
   logic [9:0]  s_vt, s_va, s_vsw;

   // Generator timing (clocks per line, lines per frame)
   int t_l, t_hs, t_hbp, t_ha, t_v, t_vs, t_vbp, t_va;

   always @(negedge clk) begin
      if (frame_valid === 1'b1) begin
         if (fv_cnt < 256) lock_hist[fv_cnt] = locked;
         s_ht = h_total; s_ha = h_active; s_hsw = h_sync_width;
         s_vt = v_total; s_va = v_active; s_vsw = v_sync_width;
         fv_cnt++;
      end
      if (error === 1'b1) err_cnt++;
   end

   task automatic set_timing(input int l, input int hs, input int hbp, input int ha,
                             input int v, input int vs, input int vbp, input int va);
      t_l = l; t_hs = hs; t_hbp = hbp; t_ha = ha;
      t_v = v; t_vs = vs; t_vbp = vbp; t_va = va;
   endtask

   task automatic gen_lines(input int first, input int last, input int stretch, input bit act_en);
      for (int ln = first; ln <= last; ln++) begin
         int len;
         len = (ln == stretch) ? t_l + 8 : t_l;
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            h_sync = (c < t_hs);
            v_sync = (ln < t_vs);
            active = act_en && (ln >= t_vs + t_vbp) && (ln < t_vs + t_vbp + t_va) &&
                     (c >= t_hs + t_hbp) && (c < t_hs + t_hbp + t_ha);
         end
      end
   endtask

   task automatic gen_frames(input int n, input bit act_en);
      for (int f = 0; f < n; f++) gen_lines(0, t_v - 1, -1, act_en);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         h_sync = 1'b0; v_sync = 1'b0; active = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; h_sync = 1'b0; v_sync = 1'b0; active = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({h_total, h_active, h_sync_width, v_total, v_active, v_sync_width} !== 66'd0) begin
         failures++; $display("FAIL reset_buses: got %h expected 0",
            {h_total, h_active, h_sync_width, v_total, v_active, v_sync_width});
      end
      checks++;
      if ({frame_valid, locked, error} !== 3'b000) begin
         failures++; $display("FAIL reset_flags: got %b expected 000", {frame_valid, locked, error});
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_lock();
      int base, e0;
      set_timing(52, 4, 6, 32, 20, 3, 2, 12);
      do_reset();
      idle(5);
      base = fv_cnt; e0 = err_cnt;
      gen_frames(5, 1'b1);
      #1;
      checks++;
      if (fv_cnt - base !== 4) begin failures++; $display("FAIL lock_fv_count: got %0d expected 4", fv_cnt - base); end
      checks++;
      if (lock_hist[base] !== 1'b0 || lock_hist[base+1] !== 1'b0) begin
         failures++; $display("FAIL lock_early: got %b%b expected 00", lock_hist[base], lock_hist[base+1]);
      end
      checks++;
      if (lock_hist[base+2] !== 1'b1) begin failures++; $display("FAIL lock_third: got %b expected 1", lock_hist[base+2]); end
      checks++;
      if (s_ht !== 12'd52) begin failures++; $display("FAIL h_total: got %0d expected 52", s_ht); end
      checks++;
      if (s_ha !== 12'd32) begin failures++; $display("FAIL h_active: got %0d expected 32", s_ha); end
      checks++;
      if (s_hsw !== 12'd4) begin failures++; $display("FAIL h_sync_width: got %0d expected 4", s_hsw); end
      checks++;
      if (s_vt !== 10'd20) begin failures++; $display("FAIL v_total: got %0d expected 20", s_vt); end
      checks++;
      if (s_va !== 10'd12) begin failures++; $display("FAIL v_active: got %0d expected 12", s_va); end
      checks++;
      if (s_vsw !== 10'd3) begin failures++; $display("FAIL v_sync_width: got %0d expected 3", s_vsw); end
      checks++;
      if (err_cnt - e0 !== 0) begin failures++; $display("FAIL lock_no_error: got %0d expected 0", err_cnt - e0); end
   endtask

   task automatic test_stretch();
      int base, e0;
      base = fv_cnt; e0 = err_cnt;
      gen_lines(0, t_v - 1, 5, 1'b1);
      #1;
      checks++;
      if (err_cnt - e0 !== 1) begin failures++; $display("FAIL stretch_error: got %0d expected 1", err_cnt - e0); end
      gen_frames(3, 1'b1);
      #1;
      checks++;
      if (fv_cnt - base !== 4) begin failures++; $display("FAIL stretch_fv_count: got %0d expected 4", fv_cnt - base); end
      checks++;
      if ({lock_hist[base], lock_hist[base+1], lock_hist[base+2], lock_hist[base+3]} !== 4'b1001) begin
         failures++; $display("FAIL stretch_lock_seq: got %b%b%b%b expected 1001",
            lock_hist[base], lock_hist[base+1], lock_hist[base+2], lock_hist[base+3]);
      end
      checks++;
      if (err_cnt - e0 !== 1) begin failures++; $display("FAIL stretch_error_total: got %0d expected 1", err_cnt - e0); end
   endtask

   task automatic test_overflow();
      int base, e0;
      base = fv_cnt; e0 = err_cnt;
      idle(4000);
      #1;
      checks++;
      if (err_cnt - e0 !== 0 || locked !== 1'b1) begin
         failures++; $display("FAIL ovf_early: got errors=%0d locked=%b expected 0 and 1", err_cnt - e0, locked);
      end
      idle(100);
      #1;
      checks++;
      if (err_cnt - e0 !== 1) begin failures++; $display("FAIL ovf_error: got %0d expected 1", err_cnt - e0); end
      checks++;
      if ({h_total, h_active, h_sync_width, v_total, v_active, v_sync_width, locked} !== 67'd0) begin
         failures++; $display("FAIL ovf_outputs: got %h expected 0",
            {h_total, h_active, h_sync_width, v_total, v_active, v_sync_width, locked});
      end
      checks++;
      if (fv_cnt - base !== 0) begin failures++; $display("FAIL ovf_no_fv: got %0d expected 0", fv_cnt - base); end
   endtask

   task automatic test_coincident();
      int base, e0;
      set_timing(40, 6, 4, 20, 16, 5, 1, 8);
      base = fv_cnt; e0 = err_cnt;
      gen_frames(4, 1'b1);
      #1;
      checks++;
      if (fv_cnt - base !== 3) begin failures++; $display("FAIL coin_fv_count: got %0d expected 3", fv_cnt - base); end
      checks++;
      if (s_vt !== 10'd16) begin failures++; $display("FAIL coin_v_total: got %0d expected 16", s_vt); end
      checks++;
      if (s_vsw !== 10'd5) begin failures++; $display("FAIL coin_v_sync_width: got %0d expected 5", s_vsw); end
      checks++;
      if ({s_ht, s_ha, s_hsw} !== {12'd40, 12'd20, 12'd6}) begin
         failures++; $display("FAIL coin_h: got %0d/%0d/%0d expected 40/20/6", s_ht, s_ha, s_hsw);
      end
      checks++;
      if (s_va !== 10'd8) begin failures++; $display("FAIL coin_v_active: got %0d expected 8", s_va); end
      checks++;
      if (lock_hist[base+1] !== 1'b0 || lock_hist[base+2] !== 1'b1) begin
         failures++; $display("FAIL coin_lock: got %b%b expected 01", lock_hist[base+1], lock_hist[base+2]);
      end
      checks++;
      if (err_cnt - e0 !== 0) begin failures++; $display("FAIL coin_no_error: got %0d expected 0", err_cnt - e0); end
   endtask

   task automatic test_reset_mid();
      int base;
      gen_lines(0, 7, -1, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({h_total, h_active, h_sync_width, v_total, v_active, v_sync_width, locked, frame_valid} !== 68'd0) begin
         failures++; $display("FAIL mid_reset_outputs: got %h expected 0",
            {h_total, h_active, h_sync_width, v_total, v_active, v_sync_width, locked, frame_valid});
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      gen_lines(8, t_v - 1, -1, 1'b1);
      base = fv_cnt;
      gen_frames(4, 1'b1);
      #1;
      checks++;
      if (fv_cnt - base !== 3) begin failures++; $display("FAIL mid_fv_count: got %0d expected 3", fv_cnt - base); end
      checks++;
      if ({lock_hist[base], lock_hist[base+1], lock_hist[base+2]} !== 3'b001) begin
         failures++; $display("FAIL mid_relock: got %b%b%b expected 001",
            lock_hist[base], lock_hist[base+1], lock_hist[base+2]);
      end
   endtask

   task automatic test_active_low();
      int base;
      set_timing(52, 4, 6, 32, 20, 3, 2, 12);
      do_reset();
      idle(5);
      base = fv_cnt;
      gen_frames(4, 1'b0);
      #1;
      checks++;
      if (fv_cnt - base !== 3) begin failures++; $display("FAIL actlow_fv_count: got %0d expected 3", fv_cnt - base); end
      checks++;
      if (s_ha !== 12'd0 || s_va !== 10'd0) begin
         failures++; $display("FAIL actlow_active: got %0d/%0d expected 0/0", s_ha, s_va);
      end
      checks++;
      if (s_ht !== 12'd52 || s_vt !== 10'd20) begin
         failures++; $display("FAIL actlow_totals: got %0d/%0d expected 52/20", s_ht, s_vt);
      end
      checks++;
      if (lock_hist[base+2] !== 1'b1) begin failures++; $display("FAIL actlow_lock: got %b expected 1", lock_hist[base+2]); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_lock();
      test_stretch();
      test_overflow();
      test_coincident();
      test_reset_mid();
      test_active_low();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
